writeback_regfile: RTL
======================

Name: writeback_regfile

Overview:
- Write-back end of the MIPS-R2000 register file: the writer matching the decode stage's read side.
- Holds the MEM/WB pipeline register and selects the write-back value (ALU result or load data).
- Commits to the 32x32 register array and serves the two decode read ports (rs/rt -> data_1/data_2).
- Counts retired instructions for bench and debug visibility.

Parameters:
- NREGS, 32, number of architectural registers (address width fixed at 5).
- WIDTH, 32, data word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  MEM stage presents a valid instruction this cycle.
- stall  input  1  freeze MEM/WB register; suppress commit.
- wb  input  2  control from the decode control unit: wb[1]=reg_write, wb[0]=mem_to_reg.
- dest  input  5  destination register number.
- alu_result  input  32  EX/MEM ALU result.
- mem_data  input  32  load data from data memory.
- rs  input  5  read address, port 1.
- rt  input  5  read address, port 2.
- data_1  output  32  register[rs].
- data_2  output  32  register[rt].
- reg_write  output  1  commit strobe this cycle (for forwarding logic).
- write_reg  output  5  register being committed.
- write_data  output  32  value being committed.
- retired  output  32  retired-instruction count.

Behaviour:
Reset (synchronous, active-high):
- Clears the MEM/WB valid bit and the latched wb/dest/data.
- Loads register i with value i for i = 0..31, so register 0 = 0.
- Clears retired to 0.
- Outputs after reset: reg_write=0, write_reg=0, write_data=0, retired=0.
- Reset asserted mid-operation discards the latched entry; no commit occurs on that edge.

MEM/WB latch (stage 1):
- On an edge with !stall, latch in_valid, wb, dest, and the selected value.
- Selected value is mem_data if wb[0]=1, otherwise alu_result.
- The selection is made at latch time; only one 32-bit data register is held.
- On an edge with stall=1, hold all latched state unchanged.

Commit (stage 2):
- reg_write = latched valid AND latched wb[1] AND latched dest != 0 AND !stall.
- write_reg = latched dest; write_data = latched data. Both are driven regardless of valid.
- On an edge with reg_write=1, register[write_reg] <= write_data.
- Latency: inputs sampled at edge N are visible in the array to reads after edge N+1.
- Register 0 is never written; a read of register 0 always returns 0.
- dest=0 with wb[1]=1 counts as retired but performs no write.

Read ports:
- Combinational array reads: data_1 = register[rs], data_2 = register[rt].
- Both ports may address the same register.

Retire counter:
- Increments by 1 on each edge where latched valid=1 and stall=0 and reset=0, whether or not the instruction writes (sw and beq retire too).
- Wraps 0xFFFFFFFF -> 0 silently.

Simultaneous events:
- stall and a valid entry: no commit and no count; the entry commits exactly once after stall deasserts.
- in_valid=1 while stall=1: the new instruction is ignored (upstream holds it).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: read ports apply write-before-read bypass. If reg_write=1 and rs==write_reg, data_1 = write_data; likewise for rt and data_2. Register 0 is never bypassed.
- Undefined: reads return array contents only; a same-cycle commit is visible on the next cycle.

Test Plan:
- Reset, then read rs=5, rt=31 -> data_1=5, data_2=31; retired=0, reg_write=0.
- R-type: in_valid=1, wb=2'b10, dest=8, alu_result=0xDEADBEEF, mem_data=0x1234 -> next cycle reg_write=1, write_reg=8, write_data=0xDEADBEEF; after the following edge, rs=8 reads 0xDEADBEEF; retired=1.
- Load: wb=2'b11, dest=9, mem_data=0xCAFEF00D, alu_result=0x40 -> register 9 = 0xCAFEF00D. Store: wb=2'b00 -> no write, retired still increments.
- Write to register 0 with value 0xFFFFFFFF -> reg_write=0, rs=0 reads 0, retired increments.
- Stall 3 cycles with a pending write to register 10 = 0x55 -> reg_write=0 and retired frozen during the stall; exactly one commit and +1 retired after release. Reset asserted during the stall -> register 10 keeps its reset value 10.
- WB_BYPASS_EN defined: commit of register 12 = 0xA5A5A5A5 with rs=12 in the same cycle -> data_1=0xA5A5A5A5. Undefined: data_1=12 that cycle, 0xA5A5A5A5 the next cycle.

Source files
------------

// File: rtl/writeback_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile_if
// Brief    : MEM/WB write-back and decode read-port bundle for writeback_regfile.
// Revision : 1.0
// ============================================================================
interface writeback_regfile_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             stall;
    logic [1:0]       wb;
    logic [4:0]       dest;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mem_data;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic             reg_write;
    logic [4:0]       write_reg;
    logic [WIDTH-1:0] write_data;
    logic [31:0]      retired;

    modport master (
        output in_valid, stall, wb, dest, alu_result, mem_data, rs, rt,
        input  data_1, data_2, reg_write, write_reg, write_data, retired
    );

    modport slave (
        input  in_valid, stall, wb, dest, alu_result, mem_data, rs, rt,
        output data_1, data_2, reg_write, write_reg, write_data, retired
    );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Brief    : MIPS-R2000 MEM/WB register, write-back select, 32x32 register
//            array with two read ports and a retired-instruction counter.
//            Optional macro WB_BYPASS_EN enables write-before-read bypass.
// Revision : 1.0
// ============================================================================
module writeback_regfile #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    writeback_regfile_if.slave  bus
);
    logic             r_valid;
    logic             r_we;
    logic [4:0]       r_dest;
    logic [WIDTH-1:0] r_data;
    logic [31:0]      r_retired;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic             w_commit;
    logic             w_retire;

    assign w_commit = r_valid && r_we && (r_dest != 5'd0) && !bus.stall;
    assign w_retire = r_valid && !bus.stall;

    // Load/ALU select happens here so only one data word is held in MEM/WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_dest  <= 5'd0;
            r_data  <= '0;
        end else if (!bus.stall) begin
            r_valid <= bus.in_valid;
            r_we    <= bus.wb[1];
            r_dest  <= bus.dest;
            r_data  <= bus.wb[0] ? bus.mem_data : bus.alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= WIDTH'(i);
            end
        end else if (w_commit) begin
            r_regs[r_dest] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

`ifdef WB_BYPASS_EN
    // w_commit already excludes register 0, so it is never bypassed.
    always_comb begin
        bus.data_1 = (w_commit && (bus.rs == r_dest)) ? r_data : r_regs[bus.rs];
        bus.data_2 = (w_commit && (bus.rt == r_dest)) ? r_data : r_regs[bus.rt];
    end
`else
    always_comb begin
        bus.data_1 = r_regs[bus.rs];
        bus.data_2 = r_regs[bus.rt];
    end
`endif

    assign bus.reg_write  = w_commit;
    assign bus.write_reg  = r_dest;
    assign bus.write_data = r_data;
    assign bus.retired    = r_retired;

endmodule
`default_nettype wire
